lift_step_pipe: RTL
===================

Name: lift_step_pipe

Overview:
Parametrised, pipelined successor to the single-sample 5/3 lifting step used in the JPEG-2000 DWT path. It performs forward or inverse predict/update on LANES independent samples per beat, using a shared mode. Row edges are handled by built-in symmetric extension. It uses a valid/ready stream handshake with full backpressure and sits between the row/column sample fetcher and the coefficient write-back.

Parameters:
W_IN, 8, sample width per lane (input operands).
SIGNED_IN, 0, 0 = inputs unsigned (pixel data), 1 = inputs two's-complement (coefficients).
LANES, 1, number of parallel lanes; all lanes share mode, edge and handshake.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n_i  in  1  asynchronous active-low reset
mode_i  in  2  00 fwd predict, 01 fwd update, 10 inv predict, 11 inv update
edge_i  in  2  bit0 = left neighbour absent, bit1 = right neighbour absent
left_i  in  LANES*W_IN  left neighbours, lane k at [k*W_IN +: W_IN]
sam_i  in  LANES*W_IN  centre samples
right_i  in  LANES*W_IN  right neighbours
valid_i  in  1  input beat valid
ready_o  out  1  block accepts beat this cycle
res_o  out  LANES*(W_IN+1)  signed results, lane k at [k*(W_IN+1) +: W_IN+1]
valid_o  out  1  output beat valid
ready_i  in  1  downstream accepts output

Behaviour:
- Reset (async, rst_n_i=0): both pipeline valid bits, valid_o and res_o go to 0 immediately. ready_o = 1 while in reset-release idle. Reset mid-stream discards all in-flight beats and produces no partial output.
- Operand extension: inputs are zero-extended (SIGNED_IN=0) or sign-extended (SIGNED_IN=1) to W_IN+3 bits internally.
- Edge substitution, per lane, before arithmetic:
  - edge_i=01: L := R.
  - edge_i=10: R := L.
  - edge_i=11: L := R := S.
  - edge_i=00: no substitution.
- Arithmetic, all floors as arithmetic right shift, P = (L+R)>>>1, U = (L+R+2)>>>2:
  - mode 00: S - P
  - mode 01: S + U
  - mode 10: S + P
  - mode 11: S - U
- Output width: the result is truncated to W_IN+1 bits signed. No saturation; legal lifting data never overflows W_IN+1.
- Pipeline: 2 stages.
  - Stage 1 registers the substituted L+R sum, S and mode.
  - Stage 2 registers the final result.
  - Latency is 2 cycles from accepted beat to valid_o when ready_i=1.
- Handshake:
  - A beat transfers on valid_i & ready_o; output transfers on valid_o & ready_i.
  - Global enable en = !valid_o | ready_i. ready_o = en (combinational from ready_i).
  - When en=0, all stage registers hold, so res_o and valid_o stay stable while valid_o=1 and ready_i=0.
  - Bubbles (valid_i=0) propagate as invalid stages. Throughput is 1 beat/cycle when ready_i is held high.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated under any ready_i pattern.
- mode_i and edge_i are sampled with the beat. Changing them between beats takes effect per beat, with no flush required.
- Lanes are fully independent arithmetically. LANES=1 with SIGNED_IN=0, W_IN=8 gives a 9-bit result, matching the legacy step.

Test Plan:
- Fwd predict, unsigned, W_IN=8: L=100, S=120, R=103, mode 00 -> res_o=19 (9'h013), valid_o two cycles after acceptance.
- Signed rounding, SIGNED_IN=1:
  - mode 00, L=-7, S=0, R=-8 -> res_o=8.
  - mode 01, L=-3, S=50, R=5 -> 51.
  - Feed 51 back with mode 11, same L/R -> 50, confirming the inverse round-trip.
- Edge handling, mode 00, unsigned:
  - edge_i=01, L=99 (ignored), S=10, R=20 -> -10.
  - edge_i=10, L=30, S=40, R=77 (ignored) -> 10.
  - edge_i=11, S=5 -> 0.
- Backpressure: stream 6 beats with S=1..6 (L=R=0, mode 00) and hold ready_i=0 for cycles 3-5.
  - Outputs are 1..6 in order, none lost.
  - res_o is stable while stalled.
  - ready_o=0 exactly when valid_o=1 and ready_i=0.
- Multi-lane, LANES=4, SIGNED_IN=0, mode 00: L=R={0,10,255,4}, S={0,10,0,255} -> res_o lanes {0,0,-255,251}.
- Async reset mid-operation: pull rst_n_i low while valid_o=1 and a beat sits in stage 1.
  - valid_o=0 and res_o=0 with no clock edge.
  - After release, the first new beat emerges with 2-cycle latency and no stale data.

Source files
------------

// File: rtl/lift_step_pipe.sv
// lift_step_pipe: 5/3 lifting predict/update (forward or inverse) on LANES samples per beat,
//   with symmetric extension at row edges. Latency 2 cycles from accepted beat to valid_o.
// Backpressure: one global enable (!valid_o | ready_i) freezes both stages; ready_o = enable.
// Ports: clk_i/rst_n_i (async active-low); mode_i/edge_i sampled with each beat;
//   left_i/sam_i/right_i lane k at [k*W_IN +: W_IN]; valid_i/ready_o input handshake;
//   res_o lane k at [k*(W_IN+1) +: W_IN+1] signed; valid_o/ready_i output handshake.
module lift_step_pipe #(
  parameter int W_IN      = 8,
  parameter int SIGNED_IN = 0,
  parameter int LANES     = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [1:0]                mode_i,
  input  logic [1:0]                edge_i,
  input  logic [LANES*W_IN-1:0]     left_i,
  input  logic [LANES*W_IN-1:0]     sam_i,
  input  logic [LANES*W_IN-1:0]     right_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [LANES*(W_IN+1)-1:0] res_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  // Internal width leaves headroom so L+R+2 and S +/- U never wrap before truncation.
  localparam int EW = W_IN + 3;
  localparam int RW = W_IN + 1;
  localparam logic signed [EW-1:0] TWO = EW'(2);

  logic                   en;
  logic                   v1_q;
  logic [1:0]             mode_q;
  logic [LANES*EW-1:0]    sum_d, sum_q;
  logic [LANES*EW-1:0]    sam_d, sam_q;
  logic [LANES*RW-1:0]    res_d;
  // Upper result bits dropped by the W_IN+1 truncation.
  logic [LANES*2-1:0]     unused_hi;

  assign en      = !valid_o || ready_i;
  assign ready_o = en;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [W_IN-1:0]       l_raw, s_raw, r_raw;
    logic signed [EW-1:0]  l_x, s_x, r_x;
    logic signed [EW-1:0]  l_e, r_e;
    logic signed [EW-1:0]  sum1, sam1, pred, upd, full;

    assign l_raw = left_i [k*W_IN +: W_IN];
    assign s_raw = sam_i  [k*W_IN +: W_IN];
    assign r_raw = right_i[k*W_IN +: W_IN];

    assign l_x = (SIGNED_IN != 0) ? {{3{l_raw[W_IN-1]}}, l_raw} : {3'b000, l_raw};
    assign s_x = (SIGNED_IN != 0) ? {{3{s_raw[W_IN-1]}}, s_raw} : {3'b000, s_raw};
    assign r_x = (SIGNED_IN != 0) ? {{3{r_raw[W_IN-1]}}, r_raw} : {3'b000, r_raw};

    // Symmetric extension: a missing neighbour mirrors the one that exists;
    // with both missing the centre sample stands in for both.
    always_comb begin
      l_e = l_x;
      r_e = r_x;
      case (edge_i)
        2'b01: l_e = r_x;
        2'b10: r_e = l_x;
        2'b11: begin
          l_e = s_x;
          r_e = s_x;
        end
        default: ;
      endcase
    end

    assign sum_d[k*EW +: EW] = l_e + r_e;
    assign sam_d[k*EW +: EW] = s_x;

    // Stage 2 arithmetic: both rounding terms are floors via arithmetic shift.
    assign sum1 = sum_q[k*EW +: EW];
    assign sam1 = sam_q[k*EW +: EW];
    assign pred = sum1 >>> 1;
    assign upd  = (sum1 + TWO) >>> 2;

    always_comb begin
      case (mode_q)
        2'b00:   full = sam1 - pred;
        2'b01:   full = sam1 + upd;
        2'b10:   full = sam1 + pred;
        default: full = sam1 - upd;
      endcase
    end

    assign res_d[k*RW +: RW]   = full[RW-1:0];
    assign unused_hi[k*2 +: 2] = full[EW-1:RW];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1_q    <= 1'b0;
      mode_q  <= 2'b00;
      sum_q   <= '0;
      sam_q   <= '0;
      valid_o <= 1'b0;
      res_o   <= '0;
    end else if (en) begin
      v1_q    <= valid_i;
      mode_q  <= mode_i;
      sum_q   <= sum_d;
      sam_q   <= sam_d;
      valid_o <= v1_q;
      res_o   <= res_d;
    end
  end

endmodule
